wb_seq_ctrl: RTL and testbench

WB_SEQ_CTRL -- requirements
Module: wb_seq_ctrl

---
 rtl/wb_seq_ctrl_pkg.sv | 32 +++
 rtl/wb_seq_ctrl_stat_decode.sv | 24 ++
 rtl/wb_seq_ctrl.sv | 115 +++++++++++
 tb/tb_wb_seq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_seq_ctrl_pkg.sv
// Shared Y86-64 write-back definitions: status codes, register IDs, icodes and the sequencer FSM states.
package wb_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WR_M = 2'd1,
    ST_STOP = 2'd2
  } state_t;

endpackage

// File: rtl/wb_seq_ctrl_stat_decode.sv
// Combinational status priority encoder: memory error, then invalid instruction, then halt.
// Zero latency; no flow control of its own, so other pipeline stages can reuse it.
module wb_seq_ctrl_stat_decode
  import wb_seq_ctrl_pkg::*;
(
  input  logic [3:0] icode_i,
  input  logic       instr_valid_i,
  input  logic       imem_error_i,
  input  logic       dmem_error_i,
  output stat_t      stat_o
);

  always_comb begin
    stat_o = STAT_AOK;
    if (imem_error_i || dmem_error_i) begin
      stat_o = STAT_ADR;
    end else if (!instr_valid_i) begin
      stat_o = STAT_INS;
    end else if (icode_i == IHALT) begin
      stat_o = STAT_HLT;
    end
  end

endmodule

// File: rtl/wb_seq_ctrl.sv
// Write-back sequencer: one registered write 1 cycle after accept; a second valM write follows for dual-dest ops.
// Not ready while the second write is pending or after a fault; a valid input that is not accepted is dropped.
module wb_seq_ctrl
  import wb_seq_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        wb_valid_i,
  output logic        wb_ready_o,
  input  logic [3:0]  icode_i,
  input  logic [3:0]  dstE_i,
  input  logic [3:0]  dstM_i,
  input  logic [63:0] valE_i,
  input  logic [63:0] valM_i,
  input  logic        instr_valid_i,
  input  logic        imem_error_i,
  input  logic        dmem_error_i,
  output logic        rf_we_o,
  output logic [3:0]  rf_waddr_o,
  output logic [63:0] rf_wdata_o,
  output logic [2:0]  stat_o,
  output logic        halted_o
);

  state_t      state_q, state_d;
  stat_t       stat_q;
  stat_t       stat_dec;
  logic        we_q, we_d;
  logic [3:0]  waddr_q, waddr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [3:0]  pend_addr_q;
  logic [63:0] pend_data_q;
  logic        accept;
  logic        e_vld, m_vld;

  wb_seq_ctrl_stat_decode u_stat_decode (
    .icode_i       (icode_i),
    .instr_valid_i (instr_valid_i),
    .imem_error_i  (imem_error_i),
    .dmem_error_i  (dmem_error_i),
    .stat_o        (stat_dec)
  );

  assign wb_ready_o = (state_q == ST_RUN);
  assign accept     = wb_valid_i && wb_ready_o;
  assign e_vld      = (dstE_i != RNONE);
  assign m_vld      = (dstM_i != RNONE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_RUN;
      stat_q      <= STAT_AOK;
      we_q        <= 1'b0;
      waddr_q     <= RNONE;
      wdata_q     <= '0;
      pend_addr_q <= RNONE;
      pend_data_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      if (accept) begin
        stat_q      <= stat_dec;
        pend_addr_q <= dstM_i;
        pend_data_q <= valM_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (stat_dec != STAT_AOK) begin
            state_d = ST_STOP;
          end else if (e_vld && m_vld && (dstE_i != dstM_i)) begin
            state_d = ST_WR_M;
            we_d    = 1'b1;
            waddr_d = dstE_i;
            wdata_d = valE_i;
          end else if (m_vld) begin
            // Covers dstE==dstM: the memory value wins the single write.
            we_d    = 1'b1;
            waddr_d = dstM_i;
            wdata_d = valM_i;
          end else if (e_vld) begin
            we_d    = 1'b1;
            waddr_d = dstE_i;
            wdata_d = valE_i;
          end
        end
      end
      ST_WR_M: begin
        state_d = ST_RUN;
        we_d    = 1'b1;
        waddr_d = pend_addr_q;
        wdata_d = pend_data_q;
      end
      ST_STOP: state_d = ST_STOP;
      default: state_d = ST_RUN;
    endcase
  end

  assign rf_we_o    = we_q;
  assign rf_waddr_o = waddr_q;
  assign rf_wdata_o = wdata_q;
  assign stat_o     = stat_q;
  assign halted_o   = (state_q == ST_STOP);

endmodule

// File: tb/tb_wb_seq_ctrl.sv
// Directed bench for wb_seq_ctrl: write sequencing, status priority, halt and reset behaviour.
module tb_wb_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        wb_valid_i = 1'b0;
  logic        wb_ready_o;
  logic [3:0]  icode_i = 4'h1;
  logic [3:0]  dstE_i = 4'hF;
  logic [3:0]  dstM_i = 4'hF;
  logic [63:0] valE_i = '0;
  logic [63:0] valM_i = '0;
  logic        instr_valid_i = 1'b1;
  logic        imem_error_i = 1'b0;
  logic        dmem_error_i = 1'b0;
  logic        rf_we_o;
  logic [3:0]  rf_waddr_o;
  logic [63:0] rf_wdata_o;
  logic [2:0]  stat_o;
  logic        halted_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  wb_seq_ctrl dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .wb_valid_i    (wb_valid_i),
    .wb_ready_o    (wb_ready_o),
    .icode_i       (icode_i),
    .dstE_i        (dstE_i),
    .dstM_i        (dstM_i),
    .valE_i        (valE_i),
    .valM_i        (valM_i),
    .instr_valid_i (instr_valid_i),
    .imem_error_i  (imem_error_i),
    .dmem_error_i  (dmem_error_i),
    .rf_we_o       (rf_we_o),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .stat_o        (stat_o),
    .halted_o      (halted_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic present(input logic [3:0] ic, input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
    wb_valid_i = 1'b1;
    icode_i    = ic;
    dstE_i     = de;
    valE_i     = ve;
    dstM_i     = dm;
    valM_i     = vm;
  endtask

  task automatic idle();
    wb_valid_i    = 1'b0;
    icode_i       = 4'h1;
    dstE_i        = 4'hF;
    dstM_i        = 4'hF;
    instr_valid_i = 1'b1;
    imem_error_i  = 1'b0;
    dmem_error_i  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    #1;
    tick();
    rst_n_i = 1'b1;
    tick();
  endtask

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #2 rst_n_i = 1'b0;
    #1;
    check("rst_we",     rf_we_o,    0);
    check("rst_waddr",  rf_waddr_o, 4'hF);
    check("rst_wdata",  rf_wdata_o, 0);
    check("rst_stat",   stat_o,     1);
    check("rst_halted", halted_o,   0);
    check("rst_ready",  wb_ready_o, 1);
    tick();
    rst_n_i = 1'b1;
    tick();
    check("post_rel_ready", wb_ready_o, 1);

    // irmovq: only dstE valid.
    present(4'h3, 4'd3, 64'h10, 4'hF, 64'h0);
    tick();
    idle();
    check("irm_we",    rf_we_o,    1);
    check("irm_addr",  rf_waddr_o, 3);
    check("irm_data",  rf_wdata_o, 64'h10);
    check("irm_stat",  stat_o,     1);
    check("irm_ready", wb_ready_o, 1);
    tick();
    check("irm_pulse_end", rf_we_o,    0);
    check("irm_hold_addr", rf_waddr_o, 3);
    check("irm_hold_data", rf_wdata_o, 64'h10);

    // popq: two writes; inputs change and a halt is offered while not ready.
    present(4'hB, 4'd4, 64'h108, 4'd2, 64'hAB);
    tick();
    check("pop_n1_we",    rf_we_o,    1);
    check("pop_n1_addr",  rf_waddr_o, 4);
    check("pop_n1_data",  rf_wdata_o, 64'h108);
    check("pop_n1_ready", wb_ready_o, 0);
    present(4'h0, 4'd9, 64'hBAD, 4'd7, 64'hDEAD);
    tick();
    idle();
    check("pop_n2_we",    rf_we_o,    1);
    check("pop_n2_addr",  rf_waddr_o, 2);
    check("pop_n2_data",  rf_wdata_o, 64'hAB);
    check("pop_n2_ready", wb_ready_o, 1);
    tick();
    check("pop_after_we",     rf_we_o,  0);
    check("pop_ignored_halt", halted_o, 0);
    check("pop_ignored_stat", stat_o,   1);

    // popq %rsp: same destination, valM wins, no extra cycle.
    present(4'hB, 4'd4, 64'h999, 4'd4, 64'h55);
    tick();
    idle();
    check("rsp_we",    rf_we_o,    1);
    check("rsp_addr",  rf_waddr_o, 4);
    check("rsp_data",  rf_wdata_o, 64'h55);
    check("rsp_ready", wb_ready_o, 1);
    tick();
    check("rsp_after_we",    rf_we_o,    0);
    check("rsp_after_ready", wb_ready_o, 1);

    // nop: both destinations RNONE.
    present(4'h1, 4'hF, 64'h1, 4'hF, 64'h2);
    tick();
    idle();
    check("nop_we",   rf_we_o,    0);
    check("nop_addr", rf_waddr_o, 4);
    check("nop_data", rf_wdata_o, 64'h55);

    // Reset during WR_M drops the pending valM write.
    present(4'hB, 4'd5, 64'h1, 4'd6, 64'h77);
    tick();
    idle();
    check("wrm_n1_addr", rf_waddr_o, 5);
    rst_n_i = 1'b0;
    #1;
    check("wrm_rst_we",    rf_we_o,    0);
    check("wrm_rst_addr",  rf_waddr_o, 4'hF);
    check("wrm_rst_data",  rf_wdata_o, 0);
    check("wrm_rst_ready", wb_ready_o, 1);
    tick();
    rst_n_i = 1'b1;
    tick();
    check("wrm_rel_we",    rf_we_o,    0);
    check("wrm_rel_addr",  rf_waddr_o, 4'hF);
    check("wrm_rel_ready", wb_ready_o, 1);

    // halt: stops, later valid pulses ignored.
    present(4'h0, 4'hF, 64'h0, 4'hF, 64'h0);
    tick();
    check("hlt_we",     rf_we_o,    0);
    check("hlt_stat",   stat_o,     2);
    check("hlt_halted", halted_o,   1);
    check("hlt_ready",  wb_ready_o, 0);
    for (int i = 0; i < 3; i++) begin
      present(4'h3, 4'd1, 64'h42, 4'hF, 64'h0);
      tick();
      check("hlt_stay_we",    rf_we_o,    0);
      check("hlt_stay_ready", wb_ready_o, 0);
      check("hlt_stay_stat",  stat_o,     2);
    end
    idle();

    // ADR beats INS.
    do_reset();
    present(4'h3, 4'd1, 64'h5, 4'hF, 64'h0);
    dmem_error_i  = 1'b1;
    instr_valid_i = 1'b0;
    tick();
    idle();
    check("adr_stat",   stat_o,     3);
    check("adr_we",     rf_we_o,    0);
    check("adr_addr",   rf_waddr_o, 4'hF);
    check("adr_halted", halted_o,   1);

    // INS beats HLT.
    do_reset();
    present(4'h0, 4'd1, 64'h5, 4'hF, 64'h0);
    instr_valid_i = 1'b0;
    tick();
    idle();
    check("ins_stat",   stat_o,   4);
    check("ins_we",     rf_we_o,  0);
    check("ins_halted", halted_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
